regfile_dump_reader: RTL and testbench

Sequential reader for the 4-entry, 32-bit register file. On a start pulse it walks a range of register addresses through the register file's combinational read port. It captures each word and streams it out over a valid/ready handshake, tagged with its register index. It sits beside the register file's write side and serves as the debug/readback path that empties the contents written by the write port.

---
 rtl/regfile_dump_reader.sv | 63 ++++++
 tb/tb_regfile_dump_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through the read port and streams words over valid/ready
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_register,
    input  logic [ADDR_WIDTH-1:0] last_register,
    output logic [ADDR_WIDTH-1:0] read_register,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_register,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] counter, end_register;
    logic handshake, last_word;

    assign read_register = counter;
    assign out_valid     = state == SEND;
    assign busy          = state != IDLE;
    assign handshake     = out_valid && out_ready;
    assign last_word     = counter == end_register;

    // next state: a word is read for one cycle, then offered until accepted
    always_comb begin
        state_next = state;
        state_next = state == IDLE ? (start ? READ : IDLE) :
                     state == READ ? SEND :
                     handshake ? (last_word ? IDLE : READ) : SEND;
    end

    // state, range counter, capture register and done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            end_register <= '0;
            out_data     <= '0;
            out_register <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_next;
            done  <= handshake && last_word;
            if (state == IDLE && start) begin
                counter      <= first_register;
                end_register <= last_register;
            end
            if (state == READ) begin
                out_data     <= read_data;
                out_register <= counter;
            end
            if (handshake && !last_word)
                counter <= counter + 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: directed checks of the dump reader against a 4-entry register file model
module tb_regfile_dump_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  first_register = '0;
    logic [1:0]  last_register = '0;
    logic [1:0]  read_register;
    logic [31:0] read_data;
    logic [31:0] out_data;
    logic [1:0]  out_register;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [31:0] regs [4];
    int checks = 0;
    int passes = 0;

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dut (
        .clock(clock), .reset(reset), .start(start),
        .first_register(first_register), .last_register(last_register),
        .read_register(read_register), .read_data(read_data),
        .out_data(out_data), .out_register(out_register), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    assign read_data = regs[read_register];

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic start_dump(input logic [1:0] f, input logic [1:0] l);
        first_register = f;
        last_register = l;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_read_register", 32'(read_register), 32'(f));
        check("start_valid_low", 32'(out_valid), 0);
    endtask

    task automatic expect_word(input logic [1:0] a, input logic [31:0] d, input logic last);
        tick;
        check("word_valid", 32'(out_valid), 1);
        check("word_register", 32'(out_register), 32'(a));
        check("word_data", out_data, d);
        tick;
        check("after_valid", 32'(out_valid), 0);
        check("after_done", 32'(done), 32'(last));
        check("after_busy", 32'(busy), 32'(!last));
    endtask

    initial begin
        regs[0] = 32'd21; regs[1] = 32'd42; regs[2] = 32'd84; regs[3] = 32'd168;
        tick;
        tick;
        reset = 1'b0;
        check("reset_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_read_register", 32'(read_register), 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_register", 32'(out_register), 0);

        start_dump(2'd0, 2'd3);
        expect_word(2'd0, 32'd21, 1'b0);
        expect_word(2'd1, 32'd42, 1'b0);
        expect_word(2'd2, 32'd84, 1'b0);
        expect_word(2'd3, 32'd168, 1'b1);
        tick;
        check("full_done_one_cycle", 32'(done), 0);
        check("full_idle_busy", 32'(busy), 0);

        start_dump(2'd3, 2'd1);
        expect_word(2'd3, 32'd168, 1'b0);
        expect_word(2'd0, 32'd21, 1'b0);
        expect_word(2'd1, 32'd42, 1'b1);
        tick;
        check("wrap_done_one_cycle", 32'(done), 0);
        check("wrap_hold_read_register", 32'(read_register), 1);

        out_ready = 1'b0;
        start_dump(2'd2, 2'd2);
        tick;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", out_data, 32'd84);
            check("stall_done", 32'(done), 0);
            tick;
        end
        out_ready = 1'b1;
        check("stall_release_valid", 32'(out_valid), 1);
        tick;
        check("stall_done", 32'(done), 1);
        check("stall_busy", 32'(busy), 0);
        tick;
        check("stall_done_clear", 32'(done), 0);

        start_dump(2'd0, 2'd3);
        tick;
        check("wr_word0", out_data, 32'd21);
        out_ready = 1'b0;
        regs[0] = 32'd55;
        regs[1] = 32'd99;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("wr_word0_held", out_data, 32'd21);
        check("wr_word0_register", 32'(out_register), 0);
        out_ready = 1'b1;
        tick;
        check("wr_after_hs_valid", 32'(out_valid), 0);
        expect_word(2'd1, 32'd99, 1'b0);
        expect_word(2'd2, 32'd84, 1'b0);
        expect_word(2'd3, 32'd168, 1'b1);
        tick;
        check("no_queued_start", 32'(busy), 0);
        tick;
        check("no_queued_start2", 32'(busy), 0);
        regs[0] = 32'd21;
        regs[1] = 32'd42;

        start_dump(2'd0, 2'd3);
        expect_word(2'd0, 32'd21, 1'b0);
        expect_word(2'd1, 32'd42, 1'b0);
        tick;
        check("pre_reset_data", out_data, 32'd84);
        reset = 1'b1;
        start = 1'b1;
        tick;
        reset = 1'b0;
        start = 1'b0;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_read_register", 32'(read_register), 0);
        start_dump(2'd1, 2'd2);
        expect_word(2'd1, 32'd42, 1'b0);
        expect_word(2'd2, 32'd84, 1'b1);

        start_dump(2'd3, 2'd3);
        expect_word(2'd3, 32'd168, 1'b1);
        start_dump(2'd0, 2'd0);
        expect_word(2'd0, 32'd21, 1'b1);
        tick;
        check("b2b_done_clear", 32'(done), 0);
        check("b2b_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
